// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte sequencer: FSM encoding, byte width and
// default timing/depth parameters.
package spi_pkg;

  localparam int BYTE_W = 8;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int LEN_W_DEF      = 8;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Byte-level handshake between the sequencer and the SPI master.
// The sequencer drives through "master"; the SPI master side uses "slave".
interface spi_byte_if;
  import spi_pkg::*;

  logic [BYTE_W-1:0] m_data_send;
  logic              m_data_valid;
  logic              m_send_completed;
  logic              m_recv_completed;
  logic [BYTE_W-1:0] m_data_recv;

  modport master (
    output m_data_send,
    output m_data_valid,
    input  m_send_completed,
    input  m_recv_completed,
    input  m_data_recv
  );

  modport slave (
    input  m_data_send,
    input  m_data_valid,
    output m_send_completed,
    output m_recv_completed,
    output m_data_recv
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data (one-cycle read latency).
// Writes when full and reads when empty are dropped; read data holds.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = rd_data_q;

  // NOTE: storage has no reset; only pointers decide what is valid, and a
  // resettable array would cost a flop reset per bit for no functional gain.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_rd) begin
        rptr_q    <= rptr_q + (AW+1)'(1);
        rd_data_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Splits host-loaded multi-byte frames into single-byte transactions for the
// byte-level SPI master, collecting received bytes into an RX FIFO.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_wr_en,
  input  logic [BYTE_W-1:0] tx_wr_data,
  output logic              tx_full,
  input  logic              rx_rd_en,
  output logic [BYTE_W-1:0] rx_rd_data,
  output logic              rx_empty,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_rx_ovf,
  spi_byte_if.master        m_if
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              seen_send_q, seen_send_d;
  logic              seen_recv_q, seen_recv_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              err_to_q, err_to_d;
  logic              err_ovf_q, err_ovf_d;

  logic              tx_pop;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_rd_data;
  logic              rx_push;
  logic              rx_full;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (tx_wr_en),
    .wr_data_i (tx_wr_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_rd_data),
    .full_o    (tx_full),
    .empty_o   (tx_empty)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (rx_push),
    .wr_data_i (m_if.m_data_recv),
    .rd_en_i   (rx_rd_en),
    .rd_data_o (rx_rd_data),
    .full_o    (rx_full),
    .empty_o   (rx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      seen_send_q <= 1'b0;
      seen_recv_q <= 1'b0;
      data_q      <= '0;
      err_to_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      seen_send_q <= seen_send_d;
      seen_recv_q <= seen_recv_d;
      data_q      <= data_d;
      err_to_q    <= err_to_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // NOTE: every signal gets its default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    seen_send_d = seen_send_q;
    seen_recv_d = seen_recv_q;
    data_d      = data_q;
    err_to_d    = err_to_q;
    err_ovf_d   = err_ovf_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_to_d  = 1'b0;
          err_ovf_d = 1'b0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        // An empty TX FIFO is an underrun the host may still fill; just wait.
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        data_d      = tx_rd_data;
        seen_send_d = 1'b0;
        seen_recv_d = 1'b0;
        timer_d     = '0;
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        timer_d = timer_q + TMR_W'(1);
        if (m_if.m_send_completed) seen_send_d = 1'b1;
        if (m_if.m_recv_completed) begin
          seen_recv_d = 1'b1;
          rx_push     = 1'b1;
          if (rx_full) err_ovf_d = 1'b1;
        end
        // Completion wins over a timeout landing in the same cycle.
        if (seen_send_d && seen_recv_d) begin
          remaining_d = remaining_q - LEN_W'(1);
          gap_d       = '0;
          state_d     = ST_GAP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = (remaining_q == '0) ? ST_DONE : ST_FETCH;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_if.m_data_send  = data_q;
  assign m_if.m_data_valid = (state_q == ST_ISSUE);
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign err_timeout       = err_to_q;
  assign err_rx_ovf        = err_ovf_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Scoreboard bench for spi_byte_sequencer: a master model answers each byte,
// monitors compare sent bytes and RX FIFO reads against queued expectations.
module tb_spi_byte_sequencer;
  import spi_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 1024;

  logic          clk;
  logic          rst_n;
  logic          tx_wr_en;
  logic [7:0]    tx_wr_data;
  logic          tx_full;
  logic          rx_rd_en;
  logic [7:0]    rx_rd_data;
  logic          rx_empty;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          err_rx_ovf;

  spi_byte_if u_if ();

  spi_byte_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LW),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_wr_en    (tx_wr_en),
    .tx_wr_data  (tx_wr_data),
    .tx_full     (tx_full),
    .rx_rd_en    (rx_rd_en),
    .rx_rd_data  (rx_rd_data),
    .rx_empty    (rx_empty),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_rx_ovf  (err_rx_ovf),
    .m_if        (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] rx;
    int         ds;
    int         dr;
  } resp_t;

  resp_t      model_q[$];
  logic [7:0] send_exp_q[$];
  logic [7:0] rx_exp_q[$];
  bit         model_en;
  int         edge_cnt = 0;
  int         done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Master model: answers each rising edge of m_data_valid with send/recv
  // pulses after per-byte delays, checking valid holds until both arrive.
  initial begin : master_model
    logic  prev;
    resp_t r;
    int    mx;
    int    mn;
    prev = 1'b0;
    u_if.m_send_completed = 1'b0;
    u_if.m_recv_completed = 1'b0;
    u_if.m_data_recv      = 8'h00;
    forever begin
      @(negedge clk);
      if (u_if.m_data_valid && !prev && model_en) begin
        check("model_q_nonempty", 32'(model_q.size() > 0), 1);
        if (model_q.size() > 0) begin
          r  = model_q.pop_front();
          mx = (r.ds > r.dr) ? r.ds : r.dr;
          mn = (r.ds < r.dr) ? r.ds : r.dr;
          for (int c = 1; c <= mx; c++) begin
            if (c > mn) check("hold_valid", 32'(u_if.m_data_valid), 1);
            u_if.m_send_completed = (c == r.ds);
            u_if.m_recv_completed = (c == r.dr);
            u_if.m_data_recv      = r.rx;
            @(negedge clk);
          end
          u_if.m_send_completed = 1'b0;
          u_if.m_recv_completed = 1'b0;
          check("drop_valid", 32'(u_if.m_data_valid), 0);
        end
      end
      prev = u_if.m_data_valid;
    end
  end

  // Valid-edge monitor: each rising edge must carry the next expected byte,
  // and the byte must stay stable while valid is high.
  initial begin : edge_monitor
    logic       prev;
    logic [7:0] held;
    prev = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (u_if.m_data_valid && !prev) begin
        edge_cnt++;
        check("edge_expected", 32'(send_exp_q.size() != 0), 1);
        if (send_exp_q.size() != 0) check("m_data_send", u_if.m_data_send, send_exp_q.pop_front());
        held = u_if.m_data_send;
      end else if (u_if.m_data_valid) begin
        check("send_stable", u_if.m_data_send, held);
      end
      prev = u_if.m_data_valid;
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  // RX read monitor: a pop accepted at a clock edge is compared after it.
  initial begin : rx_monitor
    logic pend;
    forever begin
      @(posedge clk);
      pend = rx_rd_en && !rx_empty;
      @(negedge clk);
      if (pend) begin
        check("rx_expected", 32'(rx_exp_q.size() != 0), 1);
        if (rx_exp_q.size() != 0) check("rx_rd_data", rx_rd_data, rx_exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b, input bit sent);
    @(negedge clk);
    tx_wr_en   = 1'b1;
    tx_wr_data = b;
    @(negedge clk);
    tx_wr_en = 1'b0;
    if (sent) send_exp_q.push_back(b);
  endtask

  task automatic add_resp(input logic [7:0] rx, input int ds, input int dr);
    resp_t r;
    r.rx = rx;
    r.ds = ds;
    r.dr = dr;
    model_q.push_back(r);
  endtask

  task automatic start_frame(input logic [LW-1:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rx_read(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_rd_en = 1'b1;
      @(negedge clk);
      rx_rd_en = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!u_if.m_data_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("valid_seen", 32'(u_if.m_data_valid), 1);
  endtask

  initial begin : stimulus
    int e0;
    int d0;
    int cnt;
    rst_n      = 1'b0;
    tx_wr_en   = 1'b0;
    tx_wr_data = 8'h00;
    rx_rd_en   = 1'b0;
    start      = 1'b0;
    len        = '0;
    model_en   = 1'b1;
    tick(3);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_valid", 32'(u_if.m_data_valid), 0);
    check("rst_send",  u_if.m_data_send, 8'h00);
    check("rst_rxd",   rx_rd_data, 8'h00);
    check("rst_txf",   32'(tx_full), 0);
    check("rst_rxe",   32'(rx_empty), 1);
    check("rst_errs",  {err_timeout, err_rx_ovf}, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic three-byte frame
    push_tx(8'hA5, 1); push_tx(8'h3C, 1); push_tx(8'h01, 1);
    add_resp(8'h11, 2, 2); add_resp(8'h22, 2, 2); add_resp(8'h33, 2, 2);
    e0 = edge_cnt; d0 = done_cnt;
    start_frame(3);
    wait_done(200);
    tick(3);
    check("t1_edges", edge_cnt - e0, 3);
    check("t1_done",  done_cnt - d0, 1);
    check("t1_errs",  {err_timeout, err_rx_ovf}, 0);
    check("t1_busy",  32'(busy), 0);
    check("t1_rxe",   32'(rx_empty), 0);
    rx_exp_q.push_back(8'h11); rx_exp_q.push_back(8'h22); rx_exp_q.push_back(8'h33);
    rx_read(3);
    tick(1);
    check("t1_rx_drained", 32'(rx_empty), 1);

    // Completion ordering: recv first, together, send first
    push_tx(8'h10, 1); push_tx(8'h20, 1); push_tx(8'h30, 1);
    add_resp(8'h81, 3, 1); add_resp(8'h82, 2, 2); add_resp(8'h83, 1, 3);
    e0 = edge_cnt; d0 = done_cnt;
    start_frame(3);
    wait_done(200);
    tick(3);
    check("t2_edges", edge_cnt - e0, 3);
    check("t2_done",  done_cnt - d0, 1);
    rx_exp_q.push_back(8'h81); rx_exp_q.push_back(8'h82); rx_exp_q.push_back(8'h83);
    rx_read(3);
    tick(1);
    check("t2_rx_drained", 32'(rx_empty), 1);

    // Underrun stall in FETCH
    add_resp(8'h9A, 1, 2); add_resp(8'h9B, 2, 1);
    e0 = edge_cnt; d0 = done_cnt;
    start_frame(2);
    tick(50);
    check("t3_stall_busy",  32'(busy), 1);
    check("t3_stall_valid", 32'(u_if.m_data_valid), 0);
    check("t3_stall_edges", edge_cnt - e0, 0);
    push_tx(8'h55, 1);
    tick(48);
    check("t3_mid_edges", edge_cnt - e0, 1);
    check("t3_mid_done",  done_cnt - d0, 0);
    check("t3_mid_busy",  32'(busy), 1);
    push_tx(8'h66, 1);
    wait_done(100);
    tick(3);
    check("t3_edges", edge_cnt - e0, 2);
    check("t3_done",  done_cnt - d0, 1);
    rx_exp_q.push_back(8'h9A); rx_exp_q.push_back(8'h9B);
    rx_read(2);

    // Timeout: master never answers; leftover byte goes in the next frame
    model_en = 1'b0;
    push_tx(8'hC3, 1); push_tx(8'hC4, 1);
    e0 = edge_cnt; d0 = done_cnt;
    start_frame(2);
    wait_valid(20);
    cnt = 0;
    while (u_if.m_data_valid && cnt < TMO + 10) begin
      cnt++;
      @(negedge clk);
    end
    check("t4_valid_cycles", cnt, TMO);
    check("t4_err_timeout",  32'(err_timeout), 1);
    wait_done(5);
    tick(1);
    check("t4_busy",  32'(busy), 0);
    check("t4_done",  done_cnt - d0, 1);
    check("t4_edges", edge_cnt - e0, 1);
    check("t4_err_sticky", 32'(err_timeout), 1);
    model_en = 1'b1;
    add_resp(8'h44, 1, 2);
    start_frame(1);
    check("t4_err_cleared", 32'(err_timeout), 0);
    wait_done(100);
    rx_exp_q.push_back(8'h44);
    rx_read(1);

    // RX overflow, then an empty frame
    for (int i = 0; i < DEPTH; i++) begin
      push_tx(8'(8'h60 + i), 1);
      add_resp(8'(8'h60 + i), 1, 1);
    end
    check("t5_tx_full", 32'(tx_full), 1);
    start_frame(8'(DEPTH));
    wait_done(600);
    tick(1);
    check("t5_no_ovf_yet", 32'(err_rx_ovf), 0);
    check("t5_rx_nonempty", 32'(rx_empty), 0);
    push_tx(8'hE1, 1); push_tx(8'hE2, 1);
    add_resp(8'hF1, 1, 1); add_resp(8'hF2, 2, 1);
    d0 = done_cnt;
    start_frame(2);
    wait_done(100);
    tick(1);
    check("t5_err_rx_ovf", 32'(err_rx_ovf), 1);
    check("t5_err_timeout", 32'(err_timeout), 0);
    check("t5_done", done_cnt - d0, 1);
    for (int i = 0; i < DEPTH; i++) rx_exp_q.push_back(8'(8'h60 + i));
    rx_read(DEPTH);
    tick(1);
    check("t5_rx_drained", 32'(rx_empty), 1);
    e0 = edge_cnt;
    start_frame(0);
    check("t5_len0_done", 32'(done), 1);
    check("t5_len0_clr_ovf", 32'(err_rx_ovf), 0);
    tick(1);
    check("t5_len0_pulse", 32'(done), 0);
    check("t5_len0_busy", 32'(busy), 0);
    check("t5_len0_edges", edge_cnt - e0, 0);

    // Asynchronous reset in the middle of ISSUE
    model_en = 1'b0;
    push_tx(8'h77, 1); push_tx(8'h78, 0);
    start_frame(2);
    wait_valid(20);
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(u_if.m_data_valid), 0);
    check("t6_busy",  32'(busy), 0);
    check("t6_send",  u_if.m_data_send, 8'h00);
    check("t6_rxd",   rx_rd_data, 8'h00);
    check("t6_rxe",   32'(rx_empty), 1);
    check("t6_done",  32'(done), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    model_en = 1'b1;
    push_tx(8'h12, 1);
    add_resp(8'h34, 3, 1);
    e0 = edge_cnt;
    start_frame(1);
    wait_done(100);
    tick(2);
    check("t6_edges", edge_cnt - e0, 1);
    rx_exp_q.push_back(8'h34);
    rx_read(1);
    tick(2);
    check("t6_rx_drained", 32'(rx_empty), 1);

    check("end_send_q",  send_exp_q.size(), 0);
    check("end_rx_q",    rx_exp_q.size(), 0);
    check("end_model_q", model_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
